sync_tx_fast_to_slow: RTL and testbench
=======================================

Name: sync_tx_fast_to_slow

Overview:
- Source-side transmitter of a 4-phase req/ack handshake that moves an M-bit word from the fast clock domain to a slower one.
- Used where a multi-bit value cannot simply be sampled through a flop chain because the destination clock is slower.
- Holds the data bus stable while a request is outstanding, and synchronizes the returning ack internally.
- Keeps a one-deep "latest value" pending slot and counts overwritten words.

Parameters:
- M, 15, data word width.
- SYNC_STAGES, 3, flop stages on ack_in (min 2).
- CNT_W, 8, overrun counter width.

Ports:
- clk_in  in  1  source (fast) clock.
- rst  in  1  reset, synchronous, active-high.
- data_in  in  M  word to transfer, qualified by valid_in.
- valid_in  in  1  one-cycle strobe, data_in present.
- data_out  out  M  held bus to slow domain, stable whenever req_out=1 and until ack drops.
- req_out  out  1  handshake request (registered level).
- ack_in  in  1  ack from slow domain, asynchronous to clk_in.
- idle_out  out  1  high when no transfer is in flight and the pending slot is empty.
- overrun_cnt  out  CNT_W  count of words discarded unsent; saturating.

Behaviour:
- Ack synchronizer:
  - SYNC_STAGES-flop chain on ack_in; every stage resets to 0.
  - ack_s is the last stage. Only ack_s is used by the FSM.
- States: IDLE, HOLD, RELEASE.
- Reset (synchronous, any state, mid-transfer included):
  - state=IDLE, req_out=0, data_out=0, pending_valid=0, pending data=0, overrun_cnt=0, sync chain=0.
- IDLE:
  - valid_in=1: data_out<=data_in, req_out<=1, go to HOLD. If pending_valid was also set, the pending word is discarded, overrun_cnt+1, pending_valid<=0 (newest wins).
  - Else if pending_valid: data_out<=pending, req_out<=1, pending_valid<=0, go to HOLD.
  - Else stay.
- HOLD:
  - req_out=1.
  - When ack_s=1: req_out<=0, go to RELEASE.
- RELEASE:
  - When ack_s=0: go to IDLE.
  - The next launch (from pending or valid_in) occurs in the IDLE cycle that follows, never directly out of RELEASE.
- valid_in in HOLD or RELEASE:
  - pending<=data_in, pending_valid<=1.
  - If pending_valid was already 1, the old word is lost and overrun_cnt+1.
- overrun_cnt saturates at 2^CNT_W-1; it never wraps.
- data_out changes only on the IDLE->HOLD launch edge; constant through HOLD and RELEASE.
- idle_out = (state==IDLE) && !pending_valid. Combinational from registers.
- Latency:
  - valid_in sampled in IDLE at edge k -> req_out=1 and data_out valid after edge k.
  - ack_in rise -> req_out falls SYNC_STAGES+1 edges later.
  - ack_in fall -> IDLE SYNC_STAGES+1 edges later.
- ack_s=1 while in IDLE (protocol violation): ignored. A launch still raises req; HOLD then exits as soon as ack_s=1. No lockup.

Test Plan:
- Reset, ack_in=0, valid_in=1 with data_in=15'h1234 -> next cycle req_out=1, data_out=15'h1234, idle_out=0. Raise ack_in -> req_out=0 exactly 4 clk_in edges later. Drop ack_in -> idle_out=1 4 edges later.
- In HOLD, pulse valid_in with 15'h0AAA -> data_out stays 15'h1234. After the handshake completes, IDLE launches 15'h0AAA, req_out=1 again, overrun_cnt=0.
- In HOLD, pulse valid_in with 15'h0001, 15'h0002, 15'h0003 -> only 15'h0003 is sent next, overrun_cnt=2.
- Pending 15'h0005 present in IDLE plus simultaneous valid_in with 15'h0006 -> 15'h0006 launched, pending cleared, overrun_cnt+1.
- Assert rst while in HOLD with pending set -> next cycle req_out=0, data_out=0, overrun_cnt=0, idle_out=1. A stale ack_in=1 held through reset does not launch anything.
- CNT_W=2, force 5 overruns -> overrun_cnt stops at 3.

Source files
------------

// File: rtl/sync_tx_fast_to_slow.sv
// sync_tx_fast_to_slow: 4-phase req/ack source side with ack synchronizer, latest-value pending slot and overrun counter
module sync_tx_fast_to_slow #(
   parameter int M           = 15,
   parameter int SYNC_STAGES = 3,
   parameter int CNT_W       = 8
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic [M-1:0]     data_in,
   input  logic             valid_in,
   output logic [M-1:0]     data_out,
   output logic             req_out,
   input  logic             ack_in,
   output logic             idle_out,
   output logic [CNT_W-1:0] overrun_cnt
);
   typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;
   state_t                 state, state_d;
   logic [SYNC_STAGES-1:0] ack_sync;
   logic                   ack_s, pend_v, pend_v_d, req_d, ovr;
   logic [M-1:0]           pend, pend_d, data_d;
   assign ack_s    = ack_sync[SYNC_STAGES-1];
   assign idle_out = (state == IDLE) && !pend_v;
   always_comb begin
      state_d  = state;
      req_d    = req_out;
      data_d   = data_out;
      pend_v_d = pend_v;
      pend_d   = pend;
      ovr      = 1'b0;
      case (state)
         IDLE: if (valid_in || pend_v) begin
            data_d   = valid_in ? data_in : pend;
            ovr      = valid_in && pend_v;
            req_d    = 1'b1;
            pend_v_d = 1'b0;
            state_d  = HOLD;
         end
         HOLD: if (ack_s) begin
            req_d   = 1'b0;
            state_d = RELEASE;
         end
         default: state_d = ack_s ? RELEASE : IDLE;
      endcase
      if (valid_in && state != IDLE) begin
         pend_d   = data_in;
         pend_v_d = 1'b1;
         ovr      = pend_v;
      end
   end
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state       <= IDLE;
         ack_sync    <= '0;
         req_out     <= 1'b0;
         data_out    <= '0;
         pend_v      <= 1'b0;
         pend        <= '0;
         overrun_cnt <= '0;
      end else begin
         state       <= state_d;
         ack_sync    <= {ack_sync[SYNC_STAGES-2:0], ack_in};
         req_out     <= req_d;
         data_out    <= data_d;
         pend_v      <= pend_v_d;
         pend        <= pend_d;
         overrun_cnt <= (ovr && overrun_cnt != '1) ? overrun_cnt + 1'b1 : overrun_cnt;
      end
   end
endmodule

// File: tb/tb_sync_tx_fast_to_slow.sv
// tb_sync_tx_fast_to_slow: directed test plan plus random traffic checked against a cycle reference model
module tb_sync_tx_fast_to_slow;
   localparam int M = 15, SS = 3, CMAX = 255;
   logic          clk_in = 0, rst = 1, valid_in = 0, ack_in = 0, req_out, idle_out;
   logic [M-1:0]  data_in = '0, data_out;
   logic [7:0]    overrun_cnt;
   logic          v2 = 0, ack2 = 0, r2, i2;
   logic [M-1:0]  d2 = '0, do2;
   logic [1:0]    cnt2;
   int            checks = 0, errors = 0;
   int            m_phase, m_cnt;
   logic          m_req, m_pv;
   logic [M-1:0]  m_data, m_pd;
   bit            hist[$];
   sync_tx_fast_to_slow #(.M(M), .SYNC_STAGES(SS), .CNT_W(8)) dut (
      .clk_in(clk_in), .rst(rst), .data_in(data_in), .valid_in(valid_in), .data_out(data_out),
      .req_out(req_out), .ack_in(ack_in), .idle_out(idle_out), .overrun_cnt(overrun_cnt));
   sync_tx_fast_to_slow #(.M(M), .SYNC_STAGES(SS), .CNT_W(2)) dut2 (
      .clk_in(clk_in), .rst(rst), .data_in(d2), .valid_in(v2), .data_out(do2),
      .req_out(r2), .ack_in(ack2), .idle_out(i2), .overrun_cnt(cnt2));
   always #5 clk_in = ~clk_in;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // Reference: ack seen by the transmitter is ack_in as sampled SS edges earlier
   task automatic model_step();
      bit s, bump;
      bump = 0;
      if (rst) begin
         m_phase = 0; m_req = 0; m_data = '0; m_pv = 0; m_pd = '0; m_cnt = 0;
         hist = {};
         repeat (SS) hist.push_back(1'b0);
      end else begin
         s = hist.pop_front();
         hist.push_back(ack_in);
         if (m_phase == 0) begin
            if (valid_in) begin
               bump = m_pv; m_pv = 0; m_data = data_in; m_req = 1; m_phase = 1;
            end else if (m_pv) begin
               m_pv = 0; m_data = m_pd; m_req = 1; m_phase = 1;
            end
         end else begin
            if (valid_in) begin
               bump = m_pv; m_pd = data_in; m_pv = 1;
            end
            if (m_phase == 1 && s) begin
               m_req = 0; m_phase = 2;
            end else if (m_phase == 2 && !s) m_phase = 0;
         end
         if (bump && m_cnt < CMAX) m_cnt++;
      end
   endtask
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_in);
         model_step();
         @(negedge clk_in);
         chk("m_req", req_out, m_req);
         chk("m_data", data_out, m_data);
         chk("m_idle", idle_out, m_phase == 0 && !m_pv);
         chk("m_cnt", overrun_cnt, m_cnt);
      end
   endtask
   task automatic launch(input logic [M-1:0] d);
      valid_in = 1; data_in = d; tick(); valid_in = 0;
   endtask
   task automatic handshake_to_idle();
      ack_in = 1; tick(4); ack_in = 0; tick(4);
   endtask
   initial begin
      tick(2);
      rst = 0;
      chk("rst_req", req_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_idle", idle_out, 1);
      chk("rst_cnt", overrun_cnt, 0);
      // saturating counter on the narrow instance: launch, one pending, then five overruns
      v2 = 1;
      for (int i = 0; i < 7; i++) begin
         d2 = M'(i + 1);
         tick();
         if (i == 4) chk("cnt2_at3", cnt2, 3);
      end
      v2 = 0;
      chk("cnt2_sat", cnt2, 3);
      launch(15'h1234);
      chk("t1_req", req_out, 1);
      chk("t1_data", data_out, 15'h1234);
      chk("t1_idle", idle_out, 0);
      ack_in = 1; tick(3);
      chk("t1_req_hold", req_out, 1);
      tick();
      chk("t1_req_fall", req_out, 0);
      ack_in = 0; tick(3);
      chk("t1_not_idle", idle_out, 0);
      tick();
      chk("t1_idle_back", idle_out, 1);
      launch(15'h1234);
      launch(15'h0AAA);
      chk("t2_data_held", data_out, 15'h1234);
      ack_in = 1; tick(4); ack_in = 0; tick(5);
      chk("t2_req", req_out, 1);
      chk("t2_data", data_out, 15'h0AAA);
      chk("t2_cnt", overrun_cnt, 0);
      handshake_to_idle();
      chk("t2_idle", idle_out, 1);
      launch(15'h1111);
      launch(15'h0001); launch(15'h0002); launch(15'h0003);
      chk("t3_cnt", overrun_cnt, 2);
      ack_in = 1; tick(4); ack_in = 0; tick(5);
      chk("t3_data", data_out, 15'h0003);
      chk("t3_req", req_out, 1);
      handshake_to_idle();
      launch(15'h2222);
      launch(15'h0005);
      handshake_to_idle();
      chk("t4_pend_idle", idle_out, 0);
      launch(15'h0006);
      chk("t4_data", data_out, 15'h0006);
      chk("t4_cnt", overrun_cnt, 3);
      handshake_to_idle();
      chk("t4_cleared", idle_out, 1);
      launch(15'h3333);
      launch(15'h4444);
      ack_in = 1; tick(2);
      rst = 1; tick(); rst = 0;
      chk("t5_req", req_out, 0);
      chk("t5_data", data_out, 0);
      chk("t5_cnt", overrun_cnt, 0);
      chk("t5_idle", idle_out, 1);
      tick(6);
      chk("t5_stale_req", req_out, 0);
      chk("t5_stale_idle", idle_out, 1);
      ack_in = 0; tick(4);
      for (int i = 0; i < 1500; i++) begin
         valid_in = ($urandom_range(9) < 3);
         data_in  = M'($urandom);
         if ($urandom_range(3) == 0) ack_in = req_out;
         if ($urandom_range(19) == 0) ack_in = $urandom_range(1);
         rst = ($urandom_range(299) == 0);
         tick();
      end
      rst = 0; valid_in = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
